// File: rtl/nipcb_spi_arbiter.sv
// nipcb_spi_arbiter: shares the two-slave NI PCB SPI engine between the
// stimulation DAC writer (slave 0) and the recording ADC reader (slave 1).
// Frames each granted request onto the engine send/recv/ready handshake and
// returns captured ADC samples.
//
// Optional feature macro: NIPCB_SPI_ARB_STARVE_GUARD_EN
//   defined   -> after STARVE_LIMIT consecutive DAC grants with an ADC request
//                waiting, the next grant goes to the ADC.
//   undefined -> strict DAC priority, no guard counter.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | arbitrate; grant only while the engine reports ready
// ISSUE      | send/recv pulse and matching ack are high this one cycle
// WAIT_START | wait for the engine to drop spi_ready (frame accepted)
// WAIT_DONE  | wait for spi_ready to return; capture ADC data if reading
module nipcb_spi_arbiter #(
  parameter int O_BW         = 16,
  parameter int I_BW         = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dac_req,
  input  logic [9:0]      dac_data,
  output logic            dac_ack,
  input  logic            adc_req,
  output logic            adc_ack,
  output logic [I_BW-1:0] adc_data,
  output logic            adc_valid,
  output logic [O_BW-1:0] spi_odata,
  output logic [1:0]      spi_send,
  output logic [1:0]      spi_recv,
  input  logic [I_BW-1:0] spi_idata,
  input  logic            spi_ready,
  output logic [1:0]      grant,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t state;
  logic   pick_adc;

`ifdef NIPCB_SPI_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Winner selection: DAC first unless the ADC has waited out the limit.
  always_comb begin
    pick_adc = adc_req && (!dac_req || starved);
  end

  // Saturating count of consecutive DAC grants made while the ADC waits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!adc_req) begin
        starve_cnt <= '0;
      end else if (spi_ready) begin
        if (pick_adc) begin
          starve_cnt <= '0;
        end else if (dac_req && !starved) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end
`else
  // Winner selection: strict DAC priority.
  always_comb begin
    pick_adc = adc_req && !dac_req;
  end

  // The limit only matters with the guard; referenced here so the default
  // build still elaborates the parameter.
  if (STARVE_LIMIT < 1) begin : g_limit_unused
  end
`endif

  // Frame sequencer; every output is a register so no req->pulse comb path.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      dac_ack   <= 1'b0;
      adc_ack   <= 1'b0;
      adc_data  <= '0;
      adc_valid <= 1'b0;
      spi_odata <= '0;
      spi_send  <= 2'b00;
      spi_recv  <= 2'b00;
      grant     <= 2'b00;
      busy      <= 1'b0;
    end else begin
      spi_send  <= 2'b00;
      spi_recv  <= 2'b00;
      dac_ack   <= 1'b0;
      adc_ack   <= 1'b0;
      adc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (spi_ready && (dac_req || adc_req)) begin
            state <= ISSUE;
            busy  <= 1'b1;
            if (pick_adc) begin
              spi_odata <= '0;
              spi_recv  <= 2'b10;
              adc_ack   <= 1'b1;
              grant     <= 2'b10;
            end else begin
              spi_odata <= O_BW'({1'b0, dac_data, 5'b0});
              spi_send  <= 2'b01;
              dac_ack   <= 1'b1;
              grant     <= 2'b01;
            end
          end
        end
        ISSUE: begin
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (!spi_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (spi_ready) begin
            if (grant[1]) begin
              adc_data  <= spi_idata;
              adc_valid <= 1'b1;
            end
            grant <= 2'b00;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nipcb_spi_arbiter.md
# nipcb_spi_arbiter

Shares the single two-slave NI PCB SPI engine (HP DAC on slave 0, ADC on slave 1) between the stimulation sequencer, which writes DAC codes, and the recording path, which reads ADC samples. It arbitrates requests, frames each transaction onto the SPI engine's send/recv/ready handshake, tracks frame completion, and returns captured ADC samples. The block sits between the stimulation and recording controllers and the SPI engine, and is the only driver of the engine's request inputs.

## Interface
- O_BW, 16: SPI output frame width.
- I_BW, 14: SPI input (ADC sample) width.
- STARVE_LIMIT, 4: consecutive DAC grants allowed while an ADC request waits (used only with the guard macro).

- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low.
- dac_req  in  1  level request for a DAC write; held until dac_ack.
- dac_data  in  10  {mode[1:0], magnitude[7:0]}; sampled in the grant cycle.
- dac_ack  out  1  one-cycle pulse: DAC write accepted.
- adc_req  in  1  level request for an ADC read; held until adc_ack.
- adc_ack  out  1  one-cycle pulse: ADC read accepted.
- adc_data  out  I_BW  last captured sample; holds value between captures.
- adc_valid  out  1  one-cycle pulse: adc_data updated.
- spi_odata  out  O_BW  frame to the engine.
- spi_send  out  2  per-slave send pulse {adc, dac}.
- spi_recv  out  2  per-slave receive pulse {adc, dac}.
- spi_idata  in  I_BW  engine receive data.
- spi_ready  in  1  engine idle.
- grant  out  2  one-hot current owner {adc, dac}; 0 when idle.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Engine contract: a send or recv pulse is accepted only while spi_ready=1. spi_ready falls within one cycle of the pulse and rises again when the frame completes. spi_idata is valid on the cycle spi_ready rises after a recv.
- States:
  - IDLE: arbitrate.
  - ISSUE: pulse outputs.
  - WAIT_START: wait for spi_ready=0.
  - WAIT_DONE: wait for spi_ready=1.
  - Any unused encoding goes to IDLE.
- IDLE: when spi_ready=1 and any request is present, pick the winner and go to ISSUE. When spi_ready=0, make no grant.
- Priority: DAC always wins over ADC (strict), except as modified under Configuration.
- DAC frame: spi_odata = {1'b0, dac_data, 5'b0}, spi_send = 2'b01, spi_recv = 2'b00, grant = 2'b01.
- ADC frame: spi_odata = 0, spi_send = 2'b00, spi_recv = 2'b10, grant = 2'b10.
- ISSUE: the pulses and the matching ack are high for exactly this one cycle, then go to WAIT_START.
- WAIT_START: on spi_ready=0, go to WAIT_DONE.
- WAIT_DONE: on spi_ready=1:
  - For an ADC frame, capture spi_idata into adc_data and pulse adc_valid on the next cycle.
  - Clear grant and return to IDLE.
- Requester drops its req before ack: no effect once granted. A request not yet granted is simply not seen.
- Reset: all outputs 0, adc_data 0, state IDLE, guard counter 0. Reset mid-frame abandons the frame; the engine shares rstn.

## Timing
- Request to pulse: a request sampled with spi_ready=1 in IDLE at edge N gives spi_send/recv and ack high during cycle N+1.
- Frame to valid: spi_ready rising at edge M gives adc_valid high during cycle M+1.
- Back-to-back: the earliest next grant is evaluated in the cycle after WAIT_DONE exits, so at least one idle cycle separates frames.
- All outputs are registered; there is no combinational path from req to spi_send/recv.

## Configuration
- NIPCB_SPI_ARB_STARVE_GUARD_EN defined:
  - A saturating counter counts consecutive DAC grants issued while adc_req=1.
  - When the count reaches STARVE_LIMIT and adc_req=1, the next grant goes to ADC and the counter clears.
  - The counter also clears on any ADC grant and whenever adc_req=0 in IDLE.
- Not defined: strict DAC priority, and no counter logic is synthesized.

## Test plan
- DAC write: dac_req=1, dac_data=10'h07F, spi_ready=1 -> one-cycle spi_send=2'b01 with spi_odata=16'h0FE0, dac_ack coincident, grant=2'b01 until spi_ready returns.
- ADC read: adc_req=1, engine returns 14'h2A5 -> spi_recv=2'b10 for one cycle, then adc_valid one cycle after spi_ready rises, adc_data=14'h2A5.
- Simultaneous requests in the same cycle -> DAC is served first, ADC immediately after; one idle cycle separates the two frames.
- spi_ready held low with requests pending -> no pulses and no acks; grant occurs on the first cycle spi_ready=1.
- With the guard macro defined, STARVE_LIMIT=4, both requests held continuously -> grant pattern DAC×4, ADC, DAC×4, ADC. Without the macro -> DAC only.
- rstn=0 asserted during WAIT_DONE -> all outputs 0 on the next cycle, state IDLE; a new request after reset is granted normally.
